// File: rtl/udma_pkg.sv
// rtl/udma_pkg.sv - shared uDMA widths and transfer-size encoding
package udma_pkg;

  localparam int L2_AWIDTH_NOAL = 24;
  localparam int L2_DATA_WIDTH  = 32;

  typedef enum logic [1:0] {
    DS_BYTE = 2'b00,
    DS_HALF = 2'b01,
    DS_WORD = 2'b10
  } udma_dsize_e;

endpackage

// File: rtl/udma_rr_pick.sv
// rtl/udma_rr_pick.sv - combinational round-robin search from a start pointer
module udma_rr_pick #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [IW:0]   pos;
  logic [IW-1:0] cand;

  // First set bit at or above ptr_i, wrapping past N-1 back to 0
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr_i} + (IW+1)'(i);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end
      cand = pos[IW-1:0];
      if (!found_o && mask_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/udma_l2_wr_arbiter.sv
// rtl/udma_l2_wr_arbiter.sv - two-class RR arbiter onto the single L2 write port
module udma_l2_wr_arbiter
  import udma_pkg::*;
#(
  parameter int N_REQ         = 8,
  parameter int AW            = udma_pkg::L2_AWIDTH_NOAL,
  parameter int PREFIX_W      = 32 - udma_pkg::L2_AWIDTH_NOAL,
  parameter int LP_STARVE_MAX = 4
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [N_REQ-1:0]           hp_mask_i,
  input  logic [PREFIX_W-1:0]        l2_dest_i,
  input  logic [N_REQ-1:0]           req_valid_i,
  output logic [N_REQ-1:0]           req_ready_o,
  input  logic [N_REQ*AW-1:0]        req_addr_i,
  input  logic [N_REQ*2-1:0]         req_datasize_i,
  input  logic [N_REQ*32-1:0]        req_data_i,
  output logic                       l2_req_o,
  input  logic                       l2_gnt_i,
  output logic [31:0]                l2_addr_o,
  output logic [3:0]                 l2_be_o,
  output logic [31:0]                l2_wdata_o,
  output logic [$clog2(N_REQ)-1:0]   l2_id_o
);

  localparam int IW = $clog2(N_REQ);
  localparam int SW = $clog2(LP_STARVE_MAX + 1);

  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [IW-1:0]    id_q, id_d;
  logic [IW-1:0]    hp_ptr_q, hp_ptr_d;
  logic [IW-1:0]    lp_ptr_q, lp_ptr_d;
  logic [SW-1:0]    starve_q, starve_d;

  logic [N_REQ-1:0] hp_req, lp_req;
  logic             hp_pend, lp_pend;
  logic             hp_found, lp_found;
  logic [IW-1:0]    hp_idx, lp_idx;
  logic             slot_free, take_lp, grant;
  logic [IW-1:0]    win_idx, win_next;
  logic [AW-1:0]    sel_addr;
  logic [1:0]       sel_size;
  logic [31:0]      sel_data;
  logic [3:0]       be_n;
  logic [31:0]      wdata_n;

  assign hp_req  = req_valid_i & hp_mask_i;
  assign lp_req  = req_valid_i & ~hp_mask_i;
  assign hp_pend = |hp_req;
  assign lp_pend = |lp_req;

  udma_rr_pick #(.N(N_REQ), .IW(IW)) u_pick_hp (
    .mask_i  (hp_req),
    .ptr_i   (hp_ptr_q),
    .found_o (hp_found),
    .idx_o   (hp_idx)
  );

  udma_rr_pick #(.N(N_REQ), .IW(IW)) u_pick_lp (
    .mask_i  (lp_req),
    .ptr_i   (lp_ptr_q),
    .found_o (lp_found),
    .idx_o   (lp_idx)
  );

  // Class choice, winner handshake, lane steering and next-state of slot/pointers/counter
  always_comb begin
    slot_free = !req_q || l2_gnt_i;
    take_lp   = lp_found && (!hp_found || starve_q == SW'(LP_STARVE_MAX));
    win_idx   = take_lp ? lp_idx : hp_idx;
    win_next  = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    grant     = rstn_i && slot_free && (hp_found || lp_found);

    req_ready_o = grant ? (N_REQ'(1) << win_idx) : '0;

    sel_addr = req_addr_i[win_idx*AW +: AW];
    sel_size = req_datasize_i[win_idx*2 +: 2];
    sel_data = req_data_i[win_idx*32 +: 32];

    case (udma_dsize_e'(sel_size))
      DS_BYTE: begin
        be_n    = 4'b0001 << sel_addr[1:0];
        wdata_n = {4{sel_data[7:0]}};
      end
      DS_HALF: begin
        be_n    = 4'b0011 << {sel_addr[1], 1'b0};
        wdata_n = {2{sel_data[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = sel_data;
      end
    endcase

    req_d    = req_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    id_d     = id_q;
    hp_ptr_d = hp_ptr_q;
    lp_ptr_d = lp_ptr_q;
    starve_d = starve_q;

    if (grant) begin
      req_d   = 1'b1;
      addr_d  = {l2_dest_i, sel_addr};
      be_d    = be_n;
      wdata_d = wdata_n;
      id_d    = win_idx;
      if (take_lp) begin
        lp_ptr_d = win_next;
      end else begin
        hp_ptr_d = win_next;
      end
    end else if (slot_free) begin
      req_d = 1'b0;
    end

    // Counts HP wins that bypassed a waiting LP requester
    if (!lp_pend) begin
      starve_d = '0;
    end else if (grant && take_lp) begin
      starve_d = '0;
    end else if (grant && starve_q != SW'(LP_STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Slot register, RR pointers and starvation counter
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      req_q    <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      id_q     <= '0;
      hp_ptr_q <= '0;
      lp_ptr_q <= '0;
      starve_q <= '0;
    end else begin
      req_q    <= req_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      id_q     <= id_d;
      hp_ptr_q <= hp_ptr_d;
      lp_ptr_q <= lp_ptr_d;
      starve_q <= starve_d;
    end
  end

  assign l2_req_o   = req_q;
  assign l2_addr_o  = addr_q;
  assign l2_be_o    = be_q;
  assign l2_wdata_o = wdata_q;
  assign l2_id_o    = id_q;

endmodule

// File: tb/tb_udma_l2_wr_arbiter.sv
// tb/tb_udma_l2_wr_arbiter.sv - scoreboard bench for the L2 write arbiter
module tb_udma_l2_wr_arbiter;

  localparam int N  = 8;
  localparam int AW = 24;

  typedef struct packed {
    logic [2:0]  id;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rstn_i = 1'b0;
  logic [N-1:0]    hp_mask_i = '0;
  logic [7:0]      l2_dest_i = '0;
  logic [N-1:0]    req_valid_i = '0;
  logic [N-1:0]    req_ready_o;
  logic [N*AW-1:0] req_addr_i = '0;
  logic [N*2-1:0]  req_datasize_i = '0;
  logic [N*32-1:0] req_data_i = '0;
  logic            l2_req_o;
  logic            l2_gnt_i = 1'b0;
  logic [31:0]     l2_addr_o;
  logic [3:0]      l2_be_o;
  logic [31:0]     l2_wdata_o;
  logic [2:0]      l2_id_o;

  logic [AW-1:0]   b_addr [N];
  logic [1:0]      b_size [N];
  logic [31:0]     b_data [N];

  exp_t sb [$];
  int   total = 0;
  int   bad   = 0;
  int   npop  = 0;

  always #5 clk = ~clk;

  udma_l2_wr_arbiter dut (
    .clk_i          (clk),
    .rstn_i         (rstn_i),
    .hp_mask_i      (hp_mask_i),
    .l2_dest_i      (l2_dest_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_datasize_i (req_datasize_i),
    .req_data_i     (req_data_i),
    .l2_req_o       (l2_req_o),
    .l2_gnt_i       (l2_gnt_i),
    .l2_addr_o      (l2_addr_o),
    .l2_be_o        (l2_be_o),
    .l2_wdata_o     (l2_wdata_o),
    .l2_id_o        (l2_id_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input int k, input logic [AW-1:0] a, input logic [1:0] s,
                                 input logic [31:0] d, input logic [7:0] dest);
    exp_t e;
    e.id   = 3'(k);
    e.addr = {dest, a};
    e.be   = '0;
    e.data = '0;
    for (int j = 0; j < 4; j++) begin
      case (s)
        2'b00: begin
          e.be[j]         = (j == int'(a[1:0]));
          e.data[8*j +: 8] = d[7:0];
        end
        2'b01: begin
          e.be[j]         = ((j / 2) == int'(a[1]));
          e.data[8*j +: 8] = d[8*(j%2) +: 8];
        end
        default: begin
          e.be[j]         = 1'b1;
          e.data[8*j +: 8] = d[8*j +: 8];
        end
      endcase
    end
    return e;
  endfunction

  task automatic set_req(input int k, input logic [AW-1:0] a, input logic [1:0] s, input logic [31:0] d);
    b_addr[k] = a;
    b_size[k] = s;
    b_data[k] = d;
    req_addr_i[k*AW +: AW]   = a;
    req_datasize_i[k*2 +: 2] = s;
    req_data_i[k*32 +: 32]   = d;
  endtask

  task automatic push(input int k);
    sb.push_back(model(k, b_addr[k], b_size[k], b_data[k], l2_dest_i));
  endtask

  // One clock: sample at negedge, retire a handshake against the scoreboard, then step past posedge
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (l2_req_o && l2_gnt_i) begin
      chk("xfer_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        npop++;
        chk("id", 32'(l2_id_o), 32'(e.id));
        chk("addr", l2_addr_o, e.addr);
        chk("be", 32'(l2_be_o), 32'(e.be));
        chk("wdata", l2_wdata_o, e.data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 12 && sb.size() != 0; i++) cycle();
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    exp_t st;

    // Reset with every requester asking
    for (int k = 0; k < N; k++) set_req(k, AW'(32'h100 + k*4), 2'b10, 32'hD000_0000 + k);
    l2_dest_i   = 8'h1C;
    req_valid_i = 8'hFF;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req", 32'(l2_req_o), 32'd0);
    chk("rst_addr", l2_addr_o, 32'd0);
    chk("rst_be", 32'(l2_be_o), 32'd0);
    chk("rst_wdata", l2_wdata_o, 32'd0);
    chk("rst_id", 32'(l2_id_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk); #1;

    // Round robin, all LP, grant held high: 0..7,0 with no bubbles
    rstn_i   = 1'b1;
    l2_gnt_i = 1'b1;
    for (int k = 0; k < N; k++) push(k);
    push(0);
    @(negedge clk);
    chk("first_ready", 32'(req_ready_o), 32'h01);
    @(posedge clk); #1;
    npop = 0;
    for (int i = 0; i < 8; i++) cycle();
    req_valid_i = '0;
    cycle();
    chk("rr_pops", 32'(npop), 32'd9);
    drain("rr_drain");

    // Stall: byte at lane 2 held until grant
    l2_gnt_i = 1'b0;
    set_req(3, 24'h000012, 2'b00, 32'h0000_00AB);
    req_valid_i = 8'h08;
    push(3);
    st = sb[0];
    @(negedge clk);
    chk("stall_accept_ready", 32'(req_ready_o), 32'h08);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_req", 32'(l2_req_o), 32'd1);
      chk("stall_addr", l2_addr_o, 32'h1C00_0012);
      chk("stall_be", 32'(l2_be_o), 32'b0100);
      chk("stall_wdata", l2_wdata_o, 32'hABAB_ABAB);
      chk("stall_model_wdata", l2_wdata_o, st.data);
      chk("stall_ready", 32'(req_ready_o), 32'd0);
      @(posedge clk); #1;
    end
    l2_gnt_i = 1'b1;
    push(3);
    cycle();
    req_valid_i = '0;
    drain("stall_drain");

    // Starvation guard: HP=0, LP=1
    hp_mask_i = 8'h01;
    set_req(0, 24'h000010, 2'b10, 32'h1111_1111);
    set_req(1, 24'h000020, 2'b10, 32'h2222_2222);
    req_valid_i = 8'h03;
    for (int i = 0; i < 10; i++) push((i == 4 || i == 9) ? 1 : 0);
    for (int i = 0; i < 10; i++) cycle();
    req_valid_i = '0;
    drain("starve_drain");

    // Lane steering: byte@3, half@2 with junk upper bits, size 11 as word
    hp_mask_i = '0;
    l2_dest_i = 8'h2D;
    set_req(2, 24'h000033, 2'b00, 32'hFFFF_FF5A);
    set_req(5, 24'h000102, 2'b01, 32'hFFFF_1234);
    set_req(6, 24'h000201, 2'b11, 32'hCAFE_F00D);
    req_valid_i = 8'h64;
    push(2); push(5); push(6);
    st = sb[1];
    chk("half_model_be", 32'(st.be), 32'b1100);
    chk("half_model_data", st.data, 32'h1234_1234);
    for (int i = 0; i < 3; i++) cycle();
    req_valid_i = '0;
    drain("lane_drain");

    // Reset while a transfer waits for grant: dropped, never replayed
    l2_gnt_i = 1'b0;
    set_req(4, 24'h000040, 2'b10, 32'h4444_4444);
    req_valid_i = 8'h10;
    @(negedge clk);
    chk("mr_accept_ready", 32'(req_ready_o), 32'h10);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_pending", 32'(l2_req_o), 32'd1);
    chk("mr_id", 32'(l2_id_o), 32'd4);
    @(posedge clk); #1;
    rstn_i = 1'b0;
    @(negedge clk);
    chk("mr_ready_in_reset", 32'(req_ready_o), 32'd0);
    @(posedge clk); #1;
    rstn_i      = 1'b1;
    req_valid_i = '0;
    l2_gnt_i    = 1'b1;
    @(negedge clk);
    chk("mr_req_dropped", 32'(l2_req_o), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("mr_no_replay", 32'(l2_req_o), 32'd0);
    end
    chk("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udma_l2_wr_arbiter.md
Name: udma_l2_wr_arbiter

Overview:
- Shares the single uDMA L2 write port among N_REQ RX requesters: linear channels, external channels and stream sinks.
- Uses two-class round-robin arbitration. Requesters flagged in hp_mask_i win over the rest, with an anti-starvation counter so low-priority requesters are still served.
- A one-entry output register holds address, byte enables and data stable until l2_gnt_i. Sustains one transfer per cycle under back-to-back grants.
- Sits between the RX channel units and the rx_l2_* port, clocked by the gated core clock.

Parameters:
- N_REQ, 8, number of requesters (>=2).
- AW, udma_pkg::L2_AWIDTH_NOAL, width of the non-aligned L2 byte address from requesters.
- PREFIX_W, 32-udma_pkg::L2_AWIDTH_NOAL, width of the L2 destination prefix.
- LP_STARVE_MAX, 4, consecutive high-priority grants allowed while any low-priority request is pending (>=1).

Ports:
- clk_i, in, 1, core clock.
- rstn_i, in, 1, synchronous active-low reset.
- hp_mask_i, in, N_REQ, bit k=1 puts requester k in the high-priority class (quasi-static).
- l2_dest_i, in, PREFIX_W, address MSB prefix.
- req_valid_i, in, N_REQ, per-requester write request.
- req_ready_o, out, N_REQ, one-hot acceptance.
- req_addr_i, in, N_REQ x AW, byte address.
- req_datasize_i, in, N_REQ x 2, 00 byte, 01 half, 10 word, 11 word.
- req_data_i, in, N_REQ x 32, right-aligned write data.
- l2_req_o, out, 1, L2 write request.
- l2_gnt_i, in, 1, L2 grant.
- l2_addr_o, out, 32, {l2_dest_i, addr}.
- l2_be_o, out, 4, byte enables.
- l2_wdata_o, out, 32, lane-aligned data.
- l2_id_o, out, $clog2(N_REQ), index of the requester currently presented.

Behaviour:
- Reset (rstn_i=0 at a clk_i edge):
  - l2_req_o, l2_addr_o, l2_be_o, l2_wdata_o and l2_id_o go to 0.
  - req_ready_o is 0 while rstn_i=0.
  - Both RR pointers and the starvation counter go to 0.
  - Reset mid-transfer: l2_req_o drops on the next edge and the pending transfer is discarded without acknowledgement.
- Slot free condition: slot_free = !l2_req_o | l2_gnt_i. Only when slot_free does the arbiter pick a winner. The winner's req_ready_o bit rises combinationally in the same cycle, so the handshake is valid&ready.
- Winner is latched at the edge:
  - l2_req_o=1, with address, be, data and id registered.
  - Latency from accepted request to l2_req_o is 1 cycle.
  - With slot_free=1 and no winner, l2_req_o goes to 0.
- While l2_req_o=1 and l2_gnt_i=0: all l2_* outputs hold stable and every req_ready_o bit is 0.
- Class selection:
  - HP pending = |(req_valid_i & hp_mask_i); LP pending = |(req_valid_i & ~hp_mask_i).
  - HP wins unless starve_cnt==LP_STARVE_MAX and LP pending, in which case LP wins.
  - If only one class is pending, that class wins.
- Round robin within a class: search starts at that class's pointer and proceeds upward with wrap at N_REQ-1 -> 0. After a grant to index k, that class pointer becomes (k+1) mod N_REQ; the other class's pointer is unchanged.
- starve_cnt:
  - +1 (saturating at LP_STARVE_MAX) on each HP grant while LP pending.
  - Cleared on an LP grant, or when no LP request is pending.
- Byte lanes, with a = addr[1:0]:
  - Byte: be = 4'b0001<<a; data = byte replicated in all 4 lanes.
  - Half: be = 4'b0011<<(a[1]*2); data = halfword replicated.
  - Word and 11: be = 4'b1111; data unchanged.
  - Misalignment within the lane is not checked.
- Address: l2_addr_o = {l2_dest_i, req_addr_i}, with l2_dest_i sampled at acceptance.
- A hp_mask_i change takes effect from the next arbitration. A request already in the slot is unaffected.

Decomposition:
- udma_pkg gains:
  - typedef enum logic[1:0] udma_dsize_e {DS_BYTE, DS_HALF, DS_WORD}.
  - Reuse of L2_AWIDTH_NOAL and L2_DATA_WIDTH.
- Sub-module udma_rr_pick (inputs: mask and pointer; outputs: found and index) is combinational. It is instantiated twice, once for the HP class and once for the LP class. The top holds the pointers, the counter, the slot register and the lane logic.

Test Plan:
- Reset in: req_valid_i=8'hFF during rstn_i=0 -> all outputs 0; first grant after release goes to index 0 (all LP, hp_mask_i=0).
- RR fairness: hp_mask_i=0, req_valid_i=8'hFF, l2_gnt_i=1 constant -> l2_id_o sequence 0,1,…,7,0, one per cycle, no bubbles.
- Stall: requester 3 valid, datasize=00, addr=0x00012 (AW-bit), data=0xAB, l2_dest_i=0x1C, l2_gnt_i=0 for 5 cycles -> l2_addr_o=0x1C000012 (hex digits beyond AW scale with the prefix), be=4'b0100, wdata=0xABABABAB, all stable for 5 cycles; req_ready_o=0 throughout; release on gnt.
- Starvation: hp_mask_i=8'h01, req_valid_i=8'h03, LP_STARVE_MAX=4, gnt always 1 -> grants 0,0,0,0,1,0,0,0,0,1.
- Halfword lanes: datasize=01, addr[1:0]=2, data=0x1234 -> be=4'b1100, wdata=0x12341234.
- Mid-transfer reset: l2_req_o=1, no gnt, assert rstn_i=0 for 1 cycle -> l2_req_o=0 on the next edge; the request is not replayed after reset.
